// File: rtl/ltssm_os_decoder.sv
// Per-lane PCIe training ordered-set decoder: recognises TS1/TS2 sets and logical idle.
// Each lane is an independent HUNT/FIELDS/IDENT machine that publishes a TS only once all 16 symbols check out.
module ltssm_os_lane (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] sym_data,
   input  logic       sym_k,
   input  logic       sym_valid,
   output logic       ts1_valid,
   output logic       ts2_valid,
   output logic       idle_valid,
   output logic       os_error,
   output logic [7:0] link_num,
   output logic [7:0] lane_num,
   output logic [7:0] n_fts,
   output logic [7:0] rate_id,
   output logic [7:0] training_ctrl,
   output logic       link_pad,
   output logic       lane_pad
);
   typedef enum logic [1:0] {HUNT, FIELDS, IDENT} state_t;

   state_t     state, state_nx;
   logic [3:0] idx, idx_nx;
   logic [3:0] idle_cnt, idle_nx;
   logic       sym_err, set_done;
   logic       is_com, is_pad;
   logic [7:0] sh_link, sh_lane, sh_nfts, sh_rate, sh_ctrl, sh_ident;
   logic       sh_link_pad, sh_lane_pad;

   assign is_com = sym_k && (sym_data == 8'hBC);
   assign is_pad = sym_k && (sym_data == 8'hF7);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= HUNT;
         idx      <= 4'd0;
         idle_cnt <= 4'd0;
      end else if (sym_valid) begin
         state    <= state_nx;
         idx      <= idx_nx;
         idle_cnt <= idle_nx;
      end
   end

   // A malformed symbol that is itself a COM restarts a set instead of dropping back to hunting
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      sym_err  = 1'b0;
      set_done = 1'b0;
      idle_nx  = 4'd0;
      if (state == HUNT && !sym_k && sym_data == 8'h00)
         idle_nx = (idle_cnt == 4'd8) ? 4'd8 : idle_cnt + 4'd1;
      case (state)
         HUNT: begin
            if (is_com) begin
               state_nx = FIELDS;
               idx_nx   = 4'd1;
            end
         end
         FIELDS: begin
            if (idx <= 4'd2)
               sym_err = sym_k && !is_pad;
            else
               sym_err = sym_k;
            idx_nx = idx + 4'd1;
            if (idx == 4'd5)
               state_nx = IDENT;
         end
         IDENT: begin
            if (idx == 4'd6)
               sym_err = sym_k || (sym_data != 8'h4A && sym_data != 8'h45);
            else
               sym_err = sym_k || (sym_data != sh_ident);
            if (idx == 4'd15) begin
               state_nx = HUNT;
               idx_nx   = 4'd0;
               set_done = !sym_err;
            end else begin
               idx_nx = idx + 4'd1;
            end
         end
         default: begin
            state_nx = HUNT;
            idx_nx   = 4'd0;
         end
      endcase
      if (sym_err) begin
         state_nx = is_com ? FIELDS : HUNT;
         idx_nx   = is_com ? 4'd1 : 4'd0;
      end
   end

   // Shadow fields only reach the outputs when symbol 15 completes a clean set
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ts1_valid     <= 1'b0;
         ts2_valid     <= 1'b0;
         os_error      <= 1'b0;
         idle_valid    <= 1'b0;
         link_num      <= 8'h00;
         lane_num      <= 8'h00;
         n_fts         <= 8'h00;
         rate_id       <= 8'h00;
         training_ctrl <= 8'h00;
         link_pad      <= 1'b0;
         lane_pad      <= 1'b0;
         sh_link       <= 8'h00;
         sh_lane       <= 8'h00;
         sh_nfts       <= 8'h00;
         sh_rate       <= 8'h00;
         sh_ctrl       <= 8'h00;
         sh_ident      <= 8'h00;
         sh_link_pad   <= 1'b0;
         sh_lane_pad   <= 1'b0;
      end else begin
         ts1_valid <= 1'b0;
         ts2_valid <= 1'b0;
         os_error  <= 1'b0;
         if (sym_valid) begin
            os_error   <= sym_err;
            idle_valid <= (idle_nx == 4'd8);
            if (state == FIELDS) begin
               case (idx)
                  4'd1: begin
                     sh_link     <= sym_data;
                     sh_link_pad <= is_pad;
                  end
                  4'd2: begin
                     sh_lane     <= sym_data;
                     sh_lane_pad <= is_pad;
                  end
                  4'd3: sh_nfts <= sym_data;
                  4'd4: sh_rate <= sym_data;
                  4'd5: sh_ctrl <= sym_data;
                  default: ;
               endcase
            end
            if (state == IDENT && idx == 4'd6)
               sh_ident <= sym_data;
            if (set_done) begin
               ts1_valid     <= (sh_ident == 8'h4A);
               ts2_valid     <= (sh_ident == 8'h45);
               link_num      <= sh_link;
               lane_num      <= sh_lane;
               n_fts         <= sh_nfts;
               rate_id       <= sh_rate;
               training_ctrl <= sh_ctrl;
               link_pad      <= sh_link_pad;
               lane_pad      <= sh_lane_pad;
            end
         end
      end
   end
endmodule

module ltssm_os_decoder #(
   parameter int MAX_NUM_LANES = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [MAX_NUM_LANES*8-1:0] rx_data_i,
   input  logic [MAX_NUM_LANES-1:0]   rx_datak_i,
   input  logic [MAX_NUM_LANES-1:0]   rx_valid_i,
   output logic [MAX_NUM_LANES-1:0]   ts1_valid_o,
   output logic [MAX_NUM_LANES-1:0]   ts2_valid_o,
   output logic [MAX_NUM_LANES-1:0]   idle_valid_o,
   output logic [MAX_NUM_LANES*8-1:0] link_num_o,
   output logic [MAX_NUM_LANES*8-1:0] lane_num_o,
   output logic [MAX_NUM_LANES*8-1:0] n_fts_o,
   output logic [MAX_NUM_LANES*8-1:0] rate_id_o,
   output logic [MAX_NUM_LANES*8-1:0] training_ctrl_o,
   output logic [MAX_NUM_LANES-1:0]   link_pad_o,
   output logic [MAX_NUM_LANES-1:0]   lane_pad_o,
   output logic [MAX_NUM_LANES-1:0]   os_error_o
);
   for (genvar n = 0; n < MAX_NUM_LANES; n++) begin : g_lane
      ltssm_os_lane u_lane (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .sym_data      (rx_data_i[8*n +: 8]),
         .sym_k         (rx_datak_i[n]),
         .sym_valid     (rx_valid_i[n]),
         .ts1_valid     (ts1_valid_o[n]),
         .ts2_valid     (ts2_valid_o[n]),
         .idle_valid    (idle_valid_o[n]),
         .os_error      (os_error_o[n]),
         .link_num      (link_num_o[8*n +: 8]),
         .lane_num      (lane_num_o[8*n +: 8]),
         .n_fts         (n_fts_o[8*n +: 8]),
         .rate_id       (rate_id_o[8*n +: 8]),
         .training_ctrl (training_ctrl_o[8*n +: 8]),
         .link_pad      (link_pad_o[n]),
         .lane_pad      (lane_pad_o[n])
      );
   end
endmodule

// File: tb/tb_ltssm_os_decoder.sv
// Self-checking bench for ltssm_os_decoder: directed vector table, hand-built corner sequences
// and random symbol streams compared against a position-based ordered-set model.
module tb_ltssm_os_decoder;
   localparam int NL = 4;
   localparam logic [8:0] COM   = 9'h1BC;
   localparam logic [8:0] PAD   = 9'h1F7;
   localparam logic [8:0] TS1ID = 9'h04A;
   localparam logic [8:0] TS2ID = 9'h045;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [NL*8-1:0] rx_data_i;
   logic [NL-1:0]   rx_datak_i, rx_valid_i;
   logic [NL-1:0]   ts1_valid_o, ts2_valid_o, idle_valid_o, link_pad_o, lane_pad_o, os_error_o;
   logic [NL*8-1:0] link_num_o, lane_num_o, n_fts_o, rate_id_o, training_ctrl_o;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   always #5 clk_i = ~clk_i;

   ltssm_os_decoder #(.MAX_NUM_LANES(NL)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .rx_data_i       (rx_data_i),
      .rx_datak_i      (rx_datak_i),
      .rx_valid_i      (rx_valid_i),
      .ts1_valid_o     (ts1_valid_o),
      .ts2_valid_o     (ts2_valid_o),
      .idle_valid_o    (idle_valid_o),
      .link_num_o      (link_num_o),
      .lane_num_o      (lane_num_o),
      .n_fts_o         (n_fts_o),
      .rate_id_o       (rate_id_o),
      .training_ctrl_o (training_ctrl_o),
      .link_pad_o      (link_pad_o),
      .lane_pad_o      (lane_pad_o),
      .os_error_o      (os_error_o)
   );

   // Reference model: each lane keeps the symbols of the set in progress, indexed by position
   logic [8:0] m_set [NL][16];
   int         m_len [NL];
   int         m_run [NL];
   logic       m_ts1 [NL], m_ts2 [NL], m_err [NL], m_idle [NL], m_lpad [NL], m_npad [NL];
   logic [7:0] m_link [NL], m_lane [NL], m_nfts [NL], m_rate [NL], m_ctrl [NL];
   int         obs_ts1 [NL], obs_ts2 [NL], obs_err [NL];

   typedef struct {
      logic [8:0] sym;
      logic       valid;
      logic [3:0] exp_flags;
   } vec_t;
   vec_t tbl [26];

   function automatic bit sym_ok(int l, int p, logic [8:0] s);
      if (p <= 2) return !s[8] || s == PAD;
      if (p <= 5) return !s[8];
      if (p == 6) return s == TS1ID || s == TS2ID;
      return s == m_set[l][6];
   endfunction

   task automatic model_reset();
      for (int l = 0; l < NL; l++) begin
         m_len[l] = 0;  m_run[l] = 0;
         m_ts1[l] = 0;  m_ts2[l] = 0;  m_err[l] = 0;  m_idle[l] = 0;
         m_lpad[l] = 0; m_npad[l] = 0;
         m_link[l] = 0; m_lane[l] = 0; m_nfts[l] = 0; m_rate[l] = 0; m_ctrl[l] = 0;
      end
   endtask

   task automatic model_step();
      logic [8:0] s;
      int p;
      for (int l = 0; l < NL; l++) begin
         m_ts1[l] = 0; m_ts2[l] = 0; m_err[l] = 0;
         if (rx_valid_i[l]) begin
            s = {rx_datak_i[l], rx_data_i[8*l +: 8]};
            if (m_len[l] == 0) begin
               m_run[l] = (s == 9'h000) ? ((m_run[l] < 8) ? m_run[l] + 1 : 8) : 0;
               if (s == COM) begin
                  m_set[l][0] = s;
                  m_len[l] = 1;
               end
            end else begin
               m_run[l] = 0;
               p = m_len[l];
               if (!sym_ok(l, p, s)) begin
                  m_err[l] = 1;
                  m_len[l] = (s == COM) ? 1 : 0;
               end else begin
                  m_set[l][p] = s;
                  m_len[l] = p + 1;
                  if (p == 15) begin
                     m_link[l] = m_set[l][1][7:0];  m_lpad[l] = (m_set[l][1] == PAD);
                     m_lane[l] = m_set[l][2][7:0];  m_npad[l] = (m_set[l][2] == PAD);
                     m_nfts[l] = m_set[l][3][7:0];
                     m_rate[l] = m_set[l][4][7:0];
                     m_ctrl[l] = m_set[l][5][7:0];
                     m_ts1[l]  = (m_set[l][6] == TS1ID);
                     m_ts2[l]  = (m_set[l][6] == TS2ID);
                     m_len[l]  = 0;
                  end
               end
            end
            m_idle[l] = (m_run[l] == 8);
         end
      end
   endtask

   function automatic logic [45:0] exp_vec(int l);
      return {m_ts1[l], m_ts2[l], m_err[l], m_idle[l], m_lpad[l], m_npad[l],
              m_link[l], m_lane[l], m_nfts[l], m_rate[l], m_ctrl[l]};
   endfunction

   function automatic logic [45:0] dut_vec(int l);
      return {ts1_valid_o[l], ts2_valid_o[l], os_error_o[l], idle_valid_o[l], link_pad_o[l], lane_pad_o[l],
              link_num_o[8*l +: 8], lane_num_o[8*l +: 8], n_fts_o[8*l +: 8], rate_id_o[8*l +: 8],
              training_ctrl_o[8*l +: 8]};
   endfunction

   task automatic check_val(string name, logic [31:0] got, logic [31:0] exp);
      assert_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("[TB] FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic checkOutput();
      for (int l = 0; l < NL; l++) begin
         assert_cnt++;
         if (dut_vec(l) !== exp_vec(l)) begin
            fail_cnt++;
            $display("[TB] FAIL model_cmp lane%0d got %h expected %h at %0t", l, dut_vec(l), exp_vec(l), $time);
         end
      end
   endtask

   task automatic clear_obs();
      for (int l = 0; l < NL; l++) begin
         obs_ts1[l] = 0; obs_ts2[l] = 0; obs_err[l] = 0;
      end
   endtask

   task automatic applyStimulus(input logic [NL-1:0][8:0] syms, input logic [NL-1:0] v);
      for (int l = 0; l < NL; l++) begin
         rx_data_i[8*l +: 8] = syms[l][7:0];
         rx_datak_i[l]       = syms[l][8];
      end
      rx_valid_i = v;
      @(posedge clk_i);
      model_step();
      #1;
      checkOutput();
      for (int l = 0; l < NL; l++) begin
         obs_ts1[l] += int'(ts1_valid_o[l]);
         obs_ts2[l] += int'(ts2_valid_o[l]);
         obs_err[l] += int'(os_error_o[l]);
      end
   endtask

   // ln < 0 drives every lane; otherwise only lane ln is qualified and the others see stalled garbage
   task automatic drive_one(int ln, logic [8:0] s, logic v);
      logic [NL-1:0][8:0] syms;
      logic [NL-1:0]      vv;
      for (int l = 0; l < NL; l++) begin
         if (ln < 0 || l == ln) begin
            syms[l] = s;
            vv[l]   = v;
         end else begin
            syms[l] = 9'($urandom);
            vv[l]   = 1'b0;
         end
      end
      applyStimulus(syms, vv);
   endtask

   task automatic send_ts(int ln, logic [8:0] l1, logic [8:0] l2, logic [7:0] f3, logic [7:0] f4,
                          logic [7:0] f5, logic [8:0] id, int first, int last, int bad_pos,
                          logic [8:0] bad_sym, bit toggle);
      logic [8:0] s;
      for (int p = first; p <= last; p++) begin
         case (p)
            0:       s = COM;
            1:       s = l1;
            2:       s = l2;
            3:       s = {1'b0, f3};
            4:       s = {1'b0, f4};
            5:       s = {1'b0, f5};
            default: s = id;
         endcase
         if (p == bad_pos) s = bad_sym;
         if (toggle) drive_one(ln, 9'($urandom), 1'b0);
         drive_one(ln, s, 1'b1);
      end
   endtask

   // Random generator: mostly well-formed sets with occasional corruption, noise and stalls
   int         gen_pos [NL];
   logic [8:0] gen_id  [NL];

   task automatic random_phase(int cycles);
      logic [NL-1:0][8:0] syms;
      logic [NL-1:0]      vv;
      int r;
      for (int l = 0; l < NL; l++) gen_pos[l] = 0;
      for (int c = 0; c < cycles; c++) begin
         for (int l = 0; l < NL; l++) begin
            vv[l] = ($urandom_range(0, 4) != 0);
            if (!vv[l]) begin
               syms[l] = 9'($urandom);
            end else if (gen_pos[l] == 0) begin
               r = $urandom_range(0, 9);
               if (r <= 3) begin
                  syms[l]   = COM;
                  gen_pos[l] = 1;
                  gen_id[l]  = $urandom_range(0, 1) ? TS1ID : TS2ID;
               end else if (r <= 6) syms[l] = 9'h000;
               else if (r == 7)     syms[l] = {1'b0, 8'($urandom)};
               else if (r == 8)     syms[l] = {1'b1, 8'($urandom)};
               else                 syms[l] = PAD;
            end else begin
               if (gen_pos[l] <= 2)      syms[l] = ($urandom_range(0, 2) == 0) ? PAD : {1'b0, 8'($urandom)};
               else if (gen_pos[l] <= 5) syms[l] = {1'b0, 8'($urandom)};
               else                      syms[l] = gen_id[l];
               r = $urandom_range(0, 24);
               if (r == 0)      syms[l] = 9'($urandom);
               else if (r == 1) syms[l] = COM;
               gen_pos[l] = (gen_pos[l] == 15) ? 0 : gen_pos[l] + 1;
            end
         end
         applyStimulus(syms, vv);
      end
   endtask

   initial begin
      for (int i = 0; i < 26; i++) begin
         tbl[i].valid     = 1'b1;
         tbl[i].exp_flags = 4'b0000;
         tbl[i].sym       = 9'h000;
      end
      tbl[0].sym = COM;
      tbl[1].sym = 9'h001;
      tbl[2].sym = 9'h002;
      tbl[3].sym = 9'h01F;
      tbl[4].sym = 9'h002;
      tbl[5].sym = 9'h000;
      for (int i = 6; i <= 15; i++) tbl[i].sym = TS1ID;
      tbl[15].exp_flags = 4'b1000;
      tbl[23].exp_flags = 4'b0001;
      tbl[24].valid     = 1'b0;
      tbl[24].sym       = 9'h1BC;
      tbl[24].exp_flags = 4'b0001;
      tbl[25].sym       = 9'h001;

      rst_i      = 1'b0;
      rx_data_i  = '0;
      rx_datak_i = '0;
      rx_valid_i = '0;
      model_reset();
      clear_obs();
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput();
      check_val("reset_pulses", {ts1_valid_o, ts2_valid_o, os_error_o, idle_valid_o}, 32'h0);
      rst_i = 1'b1;

      for (int i = 0; i < 26; i++) begin
         drive_one(-1, tbl[i].sym, tbl[i].valid);
         check_val("tbl_flags", {28'h0, ts1_valid_o[0], ts2_valid_o[0], os_error_o[0], idle_valid_o[0]},
                   {28'h0, tbl[i].exp_flags});
      end
      check_val("l0_link", link_num_o[7:0], 8'h01);
      check_val("l0_lane", lane_num_o[7:0], 8'h02);
      check_val("l0_nfts", n_fts_o[7:0], 8'h1F);
      check_val("l0_rate", rate_id_o[7:0], 8'h02);
      check_val("l0_ctrl", training_ctrl_o[7:0], 8'h00);
      check_val("l0_pads", {link_pad_o[0], lane_pad_o[0]}, 0);

      clear_obs();
      send_ts(1, PAD, PAD, 8'h0A, 8'h01, 8'h00, TS2ID, 0, 15, -1, 9'h0, 1'b1);
      check_val("l1_ts2_pulses", obs_ts2[1], 1);
      check_val("l1_errors", obs_err[1], 0);
      check_val("l1_pads", {link_pad_o[1], lane_pad_o[1]}, 2'b11);

      send_ts(2, 9'h011, 9'h022, 8'h33, 8'h44, 8'h55, TS1ID, 0, 15, -1, 9'h0, 1'b0);
      clear_obs();
      send_ts(2, 9'h066, 9'h077, 8'h88, 8'h99, 8'hAA, TS1ID, 0, 15, 10, TS2ID, 1'b0);
      check_val("l2_errors", obs_err[2], 1);
      check_val("l2_ts_pulses", obs_ts1[2] + obs_ts2[2], 0);
      check_val("l2_link_held", link_num_o[23:16], 8'h11);
      check_val("l2_nfts_held", n_fts_o[23:16], 8'h33);

      clear_obs();
      send_ts(3, 9'h001, 9'h002, 8'h03, 8'h04, 8'h05, TS1ID, 0, 8, 8, COM, 1'b0);
      send_ts(3, 9'h0A1, 9'h0A2, 8'hA3, 8'hA4, 8'hA5, TS2ID, 1, 15, -1, 9'h0, 1'b0);
      check_val("l3_errors", obs_err[3], 1);
      check_val("l3_ts2_pulses", obs_ts2[3], 1);
      check_val("l3_link", link_num_o[31:24], 8'hA1);
      check_val("l3_ctrl", training_ctrl_o[31:24], 8'hA5);

      drive_one(-1, 9'h001, 1'b1);
      for (int i = 0; i < 7; i++) drive_one(-1, 9'h000, 1'b1);
      check_val("idle_after7", idle_valid_o, 0);
      drive_one(-1, 9'h000, 1'b1);
      check_val("idle_after8", idle_valid_o, 4'hF);
      drive_one(-1, 9'h001, 1'b1);
      check_val("idle_cleared", idle_valid_o, 0);

      random_phase(3000);

      send_ts(-1, 9'h011, 9'h012, 8'h13, 8'h14, 8'h15, TS1ID, 0, 3, -1, 9'h0, 1'b0);
      rst_i = 1'b0;
      #1;
      model_reset();
      checkOutput();
      check_val("rst_async_fields", link_num_o | lane_num_o | n_fts_o | rate_id_o | training_ctrl_o, 0);
      check_val("rst_async_flags", {ts1_valid_o, ts2_valid_o, os_error_o, idle_valid_o, link_pad_o, lane_pad_o}, 0);
      repeat (2) begin
         @(posedge clk_i);
         #1;
         checkOutput();
      end
      rst_i = 1'b1;
      drive_one(-1, 9'h004, 1'b1);
      drive_one(-1, TS1ID, 1'b1);
      clear_obs();
      send_ts(-1, 9'h021, 9'h022, 8'h23, 8'h24, 8'h25, TS1ID, 0, 15, -1, 9'h0, 1'b0);
      send_ts(-1, 9'h031, PAD, 8'h33, 8'h34, 8'h35, TS2ID, 0, 15, -1, 9'h0, 1'b0);
      for (int l = 0; l < NL; l++) begin
         check_val("b2b_ts1", obs_ts1[l], 1);
         check_val("b2b_ts2", obs_ts2[l], 1);
         check_val("b2b_err", obs_err[l], 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end
endmodule

// File: doc/ltssm_os_decoder.md
LTSSM_OS_DECODER -- requirements
Module: ltssm_os_decoder

Interface
REQ-001 Parameter MAX_NUM_LANES, default 4, number of independent lane decoders.
REQ-002 Port clk_i  in  1  sole clock; all state on rising edge.
REQ-003 Port rst_i  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 Port rx_data_i  in  MAX_NUM_LANES*8  per-lane decoded 8b symbol; lane n at bits [8n+7:8n].
REQ-005 Port rx_datak_i  in  MAX_NUM_LANES  per-lane K-symbol flag.
REQ-006 Port rx_valid_i  in  MAX_NUM_LANES  per-lane symbol qualifier; low = stall.
REQ-007 Port ts1_valid_o  out  MAX_NUM_LANES  one-cycle pulse, complete TS1 received.
REQ-008 Port ts2_valid_o  out  MAX_NUM_LANES  one-cycle pulse, complete TS2 received.
REQ-009 Port idle_valid_o  out  MAX_NUM_LANES  level, lane sees logical idle.
REQ-010 Ports link_num_o, lane_num_o, n_fts_o, rate_id_o, training_ctrl_o  out  MAX_NUM_LANES*8 each  fields of last good TS.
REQ-011 Ports link_pad_o, lane_pad_o  out  MAX_NUM_LANES  field was PAD (K23.7, 0xF7 with K).
REQ-012 Port os_error_o  out  MAX_NUM_LANES  one-cycle pulse, malformed ordered set.

Function
REQ-013 Each lane shall run an identical, independent decoder; no cross-lane dependency.
REQ-014 Symbol accepted only when rx_valid_i[n]=1; rx_valid_i[n]=0 holds all lane state, counters and outputs (pulses deassert).
REQ-015 Lane FSM states: HUNT, FIELDS, IDENT; 4-bit symbol index 0..15.
REQ-016 HUNT: COM (0xBC, K=1) -> FIELDS, index=1; any other symbol stays HUNT, no error.
REQ-017 FIELDS symbol 1 = link, 2 = lane: data byte, or PAD (0xF7, K=1) -> pad flag set; other K -> error.
REQ-018 FIELDS symbols 3,4,5 = N_FTS, rate ID, training control; must be data (K=0), else error; after symbol 5 -> IDENT.
REQ-019 IDENT symbol 6 sets type: 0x4A (K=0) -> TS1, 0x45 (K=0) -> TS2, else error.
REQ-020 IDENT symbols 7..15 must equal symbol-6 identifier with K=0, else error.
REQ-021 Fields captured into shadow registers; copied to outputs only on acceptance of a good symbol 15; outputs otherwise unchanged.
REQ-022 Valid pulse asserts exactly 1 cycle after the clock edge accepting symbol 15; outputs updated same cycle; FSM -> HUNT.
REQ-023 Error: os_error_o pulse 1 cycle after offending symbol, shadow discarded, outputs held; if offending symbol is COM, FSM -> FIELDS index=1 (resync), else -> HUNT.
REQ-024 Idle: counter (saturating at 8) increments on data 0x00 with K=0, clears on any other accepted symbol; idle_valid_o=1 when counter=8, registered.
REQ-025 COM, PAD and identifier symbols are never counted as idle; a TS in progress clears idle counter.
REQ-026 Back-to-back TS sets (COM immediately after symbol 15) shall each decode with no lost cycle.

Reset
REQ-027 rst_i=0 forces all lanes to HUNT, index 0, idle counter 0, all outputs 0 (fields 0x00, pads 0, pulses 0) asynchronously.
REQ-028 Reset mid-ordered-set discards partial set; after release next COM starts a fresh decode.
REQ-029 Release synchronous to clk_i; first symbol accepted on first edge with rst_i=1.

Verification
REQ-030 Lane0: COM,0x01,0x02,0x1F,0x02,0x00,10x0x4A continuous -> ts1_valid_o[0] 1-cycle pulse, link=0x01, lane=0x02, n_fts=0x1F, rate=0x02, ctrl=0x00, pads=0.
REQ-031 Lane1: TS2 with PAD link/lane, rx_valid_i toggling every other cycle -> one ts2_valid_o[1] pulse, link_pad=lane_pad=1, no os_error_o.
REQ-032 Lane2: TS1 with symbol 10 = 0x45 -> os_error_o[2] pulse, no ts1/ts2 pulse, previous field outputs unchanged.
REQ-033 Lane3: COM inserted at symbol 8 then full TS2 -> one error pulse, then ts2_valid_o[3] pulse with new fields.
REQ-034 All lanes: 7x data 0x00 -> idle_valid_o=0; 8th -> idle_valid_o=1 next cycle; one 0x01 -> 0; rst_i=0 mid-TS -> all outputs 0 immediately.
